// File: rtl/regfile_writeback_if.sv
// Result/write-back bundle between the producing pipeline stages, the write-back
// buffer and the register-file write port, including the decode-stage bypass lookup.
interface regfile_writeback_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          res_valid;
    logic          res_ready;
    logic [4:0]    res_reg;
    logic [31:0]   res_data;
    logic          wb_stall;
    logic          RegWrite;
    logic [4:0]    write_reg;
    logic [31:0]   write_data;
    logic [4:0]    chk_reg_1;
    logic [4:0]    chk_reg_2;
    logic          chk_hit_1;
    logic          chk_hit_2;
    logic [31:0]   chk_data_1;
    logic [31:0]   chk_data_2;
    logic [CW-1:0] pending;

    modport master (
        output res_valid, res_reg, res_data, wb_stall, chk_reg_1, chk_reg_2,
        input  res_ready, RegWrite, write_reg, write_data,
        input  chk_hit_1, chk_hit_2, chk_data_1, chk_data_2, pending
    );

    modport slave (
        input  res_valid, res_reg, res_data, wb_stall, chk_reg_1, chk_reg_2,
        output res_ready, RegWrite, write_reg, write_data,
        output chk_hit_1, chk_hit_2, chk_data_1, chk_data_2, pending
    );
endinterface

// File: rtl/regfile_writeback.sv
// In-order write-back FIFO feeding the register-file write port, with a
// combinational bypass lookup over the still-queued results.
module regfile_writeback #(
    parameter int unsigned DEPTH = 4
) (
    input logic               clk,
    input logic               rst,
    regfile_writeback_if.slave wb
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [4:0]    r_reg  [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic          w_ready;
    logic          w_accept;
    logic          w_retire;
    logic [32:0]   w_look_1;
    logic [32:0]   w_look_2;

    // Walk from oldest to youngest so the last match seen is the youngest one.
    function automatic logic [32:0] lookup(input logic [4:0] r);
        logic [32:0]   res;
        logic [PW-1:0] idx;
        res = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = r_head + PW'(i);
            if (r_valid[idx] && (r_reg[idx] == r) && (r != 5'd0)) begin
                res = {1'b1, r_data[idx]};
            end
        end
        return res;
    endfunction

    // Ready looks only at registered occupancy, so a same-cycle retire never opens a full buffer.
    assign w_ready  = !rst && (r_count < CW'(DEPTH));
    assign w_accept = wb.res_valid && w_ready && (wb.res_reg != 5'd0);
    assign w_retire = !rst && (r_count != '0) && !wb.wb_stall;

    always_comb begin
        w_look_1 = '0;
        w_look_2 = '0;
        if (!rst) begin
            w_look_1 = lookup(wb.chk_reg_1);
            w_look_2 = lookup(wb.chk_reg_2);
        end
    end

    assign wb.res_ready  = w_ready;
    assign wb.RegWrite   = w_retire;
    assign wb.write_reg  = w_retire ? r_reg[r_head]  : '0;
    assign wb.write_data = w_retire ? r_data[r_head] : '0;
    assign wb.chk_hit_1  = w_look_1[32];
    assign wb.chk_data_1 = w_look_1[31:0];
    assign wb.chk_hit_2  = w_look_2[32];
    assign wb.chk_data_2 = w_look_2[31:0];
    assign wb.pending    = r_count;

    // Accept and retire never target the same slot: that would need the buffer both empty and full.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) begin
                r_reg[r_tail]   <= wb.res_reg;
                r_data[r_tail]  <= wb.res_data;
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + 1'b1;
            end
            if (w_retire) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            r_count <= r_count + CW'(w_accept) - CW'(w_retire);
        end
    end
endmodule
